// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared constants for the RV32I decode/sequencer slice.
//               Holds the ALU opcode encoding, the RV32I major opcodes and
//               the five sequencer phases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  // ALU opcode encoding consumed by the execute stage
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SLT  = 5'd1;
  localparam logic [4:0] ALU_SLTU = 5'd2;
  localparam logic [4:0] ALU_XOR  = 5'd3;
  localparam logic [4:0] ALU_OR   = 5'd4;
  localparam logic [4:0] ALU_AND  = 5'd5;
  localparam logic [4:0] ALU_SLL  = 5'd6;
  localparam logic [4:0] ALU_SRL  = 5'd7;
  localparam logic [4:0] ALU_SRA  = 5'd8;
  localparam logic [4:0] ALU_SUB  = 5'd9;
  localparam logic [4:0] ALU_SLLR = 5'd10;
  localparam logic [4:0] ALU_SLTR = 5'd11;
  localparam logic [4:0] ALU_XORR = 5'd13;
  localparam logic [4:0] ALU_SRLR = 5'd14;
  localparam logic [4:0] ALU_SRAR = 5'd15;
  localparam logic [4:0] ALU_ORR  = 5'd16;
  localparam logic [4:0] ALU_ANDR = 5'd17;
  localparam logic [4:0] ALU_BEQ  = 5'd18;
  localparam logic [4:0] ALU_BNE  = 5'd19;
  localparam logic [4:0] ALU_BLT  = 5'd20;
  localparam logic [4:0] ALU_BGE  = 5'd21;
  localparam logic [4:0] ALU_BLTU = 5'd22;
  localparam logic [4:0] ALU_BGEU = 5'd23;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Sequencer phases
  typedef enum logic [2:0] {
    PH_FETCH  = 3'd0,
    PH_DECODE = 3'd1,
    PH_EXEC   = 3'd2,
    PH_MEM    = 3'd3,
    PH_WB     = 3'd4
  } phase_e;

endpackage

`default_nettype wire

// File: rtl/riscv_decode_seq_imm_gen.sv
// ============================================================================
// Module      : imm_gen
// Description : Combinational RV32I immediate extraction (I/S/B/U/J forms),
//               all sign-extended to 32 bits.
// Ports       : instr  - instruction word
//               imm_i, imm_s, imm_b, imm_u, imm_j - decoded immediates
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen (
  input  logic [31:0] instr,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_u,
  output logic [31:0] imm_j
);

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

`default_nettype wire

// File: rtl/riscv_decode_seq.sv
// ============================================================================
// Module      : riscv_decode_seq
// Description : RV32I decode stage and 5-phase instruction sequencer
//               (fetch, decode, execute, memory, writeback). Latches an
//               instruction over a valid/ready handshake, reads the register
//               file in decode and registers the ALU operands for execute.
// Ports       : clk/rst                 - clock, sync active-high reset
//               instr_valid/instr/instr_pc/instr_ready - fetch handshake
//               rs1_addr/rs2_addr/rs1_data/rs2_data   - register-file read
//               phase/op/opa/opb         - ALU controls and operands
//               rd_addr/rd_we            - writeback control
//               mem_req/mem_we/mem_funct3/mem_ack - load/store control
//               is_branch/is_jump/illegal_instr/halted - status
// Options     : DECODE_ILLEGAL_TRAP_EN - illegal instruction halts the
//               sequencer until reset; otherwise it executes as a NOP.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_decode_seq
  import riscv_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] instr_pc,
  output logic            instr_ready,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [2:0]      phase,
  output logic [4:0]      op,
  output logic [XLEN-1:0] opa,
  output logic [XLEN-1:0] opb,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
  output logic            mem_req,
  output logic            mem_we,
  output logic [2:0]      mem_funct3,
  input  logic            mem_ack,
  output logic            is_branch,
  output logic            is_jump,
  output logic            illegal_instr,
  output logic            halted
);

  phase_e          state, state_nxt;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;
  logic            is_mem_q;
  logic            wb_q;

  logic [31:0] imm_i, imm_s, imm_u, unused_imm_b, unused_imm_j;

  imm_gen u_imm_gen (
    .instr (instr_q),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_b (unused_imm_b),
    .imm_u (imm_u),
    .imm_j (unused_imm_j)
  );

  wire [6:0] opcode = instr_q[6:0];
  wire [2:0] funct3 = instr_q[14:12];
  wire [6:0] funct7 = instr_q[31:25];

  assign rs1_addr = instr_q[19:15];
  assign rs2_addr = instr_q[24:20];
  assign phase    = state;

  // ---------------------------------------------------------------- decode
  logic [4:0]      d_op;
  logic [XLEN-1:0] d_opa, d_opb;
  logic            d_branch, d_jump, d_illegal, d_mem, d_mem_we, d_wb;
  logic [2:0]      d_mem_f3;

  always_comb begin
    d_op      = ALU_ADD;
    d_opa     = '0;
    d_opb     = '0;
    d_branch  = 1'b0;
    d_jump    = 1'b0;
    d_illegal = 1'b0;
    d_mem     = 1'b0;
    d_mem_we  = 1'b0;
    d_mem_f3  = 3'b000;
    d_wb      = 1'b0;
    case (opcode)
      OPC_LUI: begin
        d_opb = imm_u;
        d_wb  = 1'b1;
      end
      OPC_AUIPC: begin
        d_opa = pc_q;
        d_opb = imm_u;
        d_wb  = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        d_opa  = pc_q;
        d_opb  = 32'd4;
        d_jump = 1'b1;
        d_wb   = 1'b1;
      end
      OPC_LOAD: begin
        d_opa    = rs1_data;
        d_opb    = imm_i;
        d_mem    = 1'b1;
        d_mem_f3 = funct3;
        d_wb     = 1'b1;
      end
      OPC_STORE: begin
        d_opa    = rs1_data;
        d_opb    = imm_s;
        d_mem    = 1'b1;
        d_mem_we = 1'b1;
        d_mem_f3 = funct3;
      end
      OPC_OPIMM: begin
        d_opa = rs1_data;
        d_opb = imm_i;
        d_wb  = 1'b1;
        case (funct3)
          3'b000: d_op = ALU_ADD;
          3'b010: d_op = ALU_SLT;
          3'b011: d_op = ALU_SLTU;
          3'b100: d_op = ALU_XOR;
          3'b110: d_op = ALU_OR;
          3'b111: d_op = ALU_AND;
          3'b001: begin
            d_op      = ALU_SLL;
            d_opb     = {27'b0, instr_q[24:20]};
            d_illegal = (funct7 != 7'h00);
          end
          default: begin // 3'b101
            d_op      = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
            d_opb     = {27'b0, instr_q[24:20]};
            d_illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
          end
        endcase
      end
      OPC_OP: begin
        d_opa = rs1_data;
        d_opb = rs2_data;
        d_wb  = 1'b1;
        // funct7 0x20 only qualifies SUB and SRA
        d_illegal = ((funct7 != 7'h00) && (funct7 != 7'h20)) ||
                    ((funct7 == 7'h20) && (funct3 != 3'b000) && (funct3 != 3'b101));
        case (funct3)
          3'b000: d_op = funct7[5] ? ALU_SUB : ALU_ADD;
          3'b001: begin
            d_op  = ALU_SLLR;
            d_opb = {27'b0, rs2_data[4:0]};
          end
          3'b010: d_op = ALU_SLTR;
          3'b011: d_op = ALU_SLTU;
          3'b100: d_op = ALU_XORR;
          3'b101: begin
            d_op  = funct7[5] ? ALU_SRAR : ALU_SRLR;
            d_opb = {27'b0, rs2_data[4:0]};
          end
          3'b110: d_op = ALU_ORR;
          default: d_op = ALU_ANDR;
        endcase
      end
      OPC_BRANCH: begin
        d_opa    = rs1_data;
        d_opb    = rs2_data;
        d_branch = 1'b1;
        case (funct3)
          3'b000:  d_op = ALU_BEQ;
          3'b001:  d_op = ALU_BNE;
          3'b100:  d_op = ALU_BLT;
          3'b101:  d_op = ALU_BGE;
          3'b110:  d_op = ALU_BLTU;
          3'b111:  d_op = ALU_BGEU;
          default: d_illegal = 1'b1;
        endcase
      end
      default: d_illegal = 1'b1;
    endcase

    // Illegal instructions collapse to an inert add of zeros
    if (d_illegal) begin
      d_op     = ALU_ADD;
      d_opa    = '0;
      d_opb    = '0;
      d_branch = 1'b0;
      d_jump   = 1'b0;
      d_mem    = 1'b0;
      d_mem_we = 1'b0;
      d_mem_f3 = 3'b000;
      d_wb     = 1'b0;
    end
  end

  // ------------------------------------------------------------ sequencer
  always_ff @(posedge clk) begin
    if (rst) state <= PH_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    mem_req     = 1'b0;
    rd_we       = 1'b0;
    case (state)
      PH_FETCH: begin
        instr_ready = !halted;
        if (instr_valid && !halted) state_nxt = PH_DECODE;
      end
      PH_DECODE: state_nxt = PH_EXEC;
      PH_EXEC:   state_nxt = is_mem_q ? PH_MEM : PH_WB;
      PH_MEM: begin
        mem_req = 1'b1;
        if (mem_ack) state_nxt = PH_WB;
      end
      PH_WB: begin
        rd_we     = wb_q && (rd_addr != 5'd0);
        state_nxt = PH_FETCH;
      end
      default: state_nxt = PH_FETCH;
    endcase
  end

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q       <= '0;
      pc_q          <= RESET_PC;
      op            <= ALU_ADD;
      opa           <= '0;
      opb           <= '0;
      rd_addr       <= '0;
      is_branch     <= 1'b0;
      is_jump       <= 1'b0;
      illegal_instr <= 1'b0;
      is_mem_q      <= 1'b0;
      mem_we        <= 1'b0;
      mem_funct3    <= 3'b000;
      wb_q          <= 1'b0;
    end else begin
      if (state == PH_FETCH && instr_valid && instr_ready) begin
        instr_q <= instr;
        pc_q    <= instr_pc;
      end
      // Operands are captured on the decode exit edge so they stay stable
      // for the whole execute phase.
      if (state == PH_DECODE) begin
        op            <= d_op;
        opa           <= d_opa;
        opb           <= d_opb;
        rd_addr       <= instr_q[11:7];
        is_branch     <= d_branch;
        is_jump       <= d_jump;
        illegal_instr <= d_illegal;
        is_mem_q      <= d_mem;
        mem_we        <= d_mem_we;
        mem_funct3    <= d_mem_f3;
        wb_q          <= d_wb;
      end
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic halted_q;
  always_ff @(posedge clk) begin
    if (rst)                                 halted_q <= 1'b0;
    else if (state == PH_WB && illegal_instr) halted_q <= 1'b1;
  end
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_riscv_decode_seq.sv
// ============================================================================
// Module      : tb_riscv_decode_seq
// Description : Directed self-checking bench for riscv_decode_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_decode_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr, instr_pc;
  logic        instr_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [2:0]  phase;
  logic [4:0]  op;
  logic [31:0] opa, opb;
  logic [4:0]  rd_addr;
  logic        rd_we, mem_req, mem_we;
  logic [2:0]  mem_funct3;
  logic        mem_ack;
  logic        is_branch, is_jump, illegal_instr, halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_decode_seq #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .phase         (phase),
    .op            (op),
    .opa           (opa),
    .opb           (opb),
    .rd_addr       (rd_addr),
    .rd_we         (rd_we),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_funct3    (mem_funct3),
    .mem_ack       (mem_ack),
    .is_branch     (is_branch),
    .is_jump       (is_jump),
    .illegal_instr (illegal_instr),
    .halted        (halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Offer one instruction while in phase 0; returns at the phase-1 negedge
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    instr       = ins;
    instr_pc    = pc;
    rs1_data    = r1;
    rs2_data    = r2;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    check("phase_decode", 32'(phase), 32'd1);
  endtask

  // Called at the first phase-0 negedge after an illegal instruction
  task automatic after_illegal(input string tag);
`ifdef DECODE_ILLEGAL_TRAP_EN
    check({tag, "_halted"}, 32'(halted), 32'd1);
    instr_valid = 1'b1;
    instr       = 32'h00000013;
    for (int i = 0; i < 3; i++) begin
      check({tag, "_halt_ready"}, 32'(instr_ready), 32'd0);
      step();
      check({tag, "_halt_phase"}, 32'(phase), 32'd0);
    end
    instr_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check({tag, "_unhalt"}, 32'(halted), 32'd0);
    check({tag, "_unhalt_ready"}, 32'(instr_ready), 32'd1);
`else
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_ready"}, 32'(instr_ready), 32'd1);
`endif
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; instr_pc = '0;
    rs1_data = '0; rs2_data = '0; mem_ack = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_op", 32'(op), 32'd0);
    check("rst_opa", opa, 32'h0);
    check("rst_opb", opb, 32'h0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_rd_we", 32'(rd_we), 32'd0);
    check("rst_illegal", 32'(illegal_instr), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    // addi x1,x0,-5
    issue(32'hFFB00093, 32'h10, 32'h0, 32'h0);
    check("addi_rs1_addr", 32'(rs1_addr), 32'd0);
    step();
    check("addi_phase", 32'(phase), 32'd2);
    check("addi_op", 32'(op), 32'd0);
    check("addi_opa", opa, 32'h0);
    check("addi_opb", opb, 32'hFFFFFFFB);
    check("addi_illegal", 32'(illegal_instr), 32'd0);
    step();
    check("addi_wb_phase", 32'(phase), 32'd4);
    check("addi_rd_we", 32'(rd_we), 32'd1);
    check("addi_rd_addr", 32'(rd_addr), 32'd1);
    step();
    check("addi_back_fetch", 32'(phase), 32'd0);
    check("addi_rd_we_off", 32'(rd_we), 32'd0);

    // sra x3,x1,x2
    issue(32'h4020D1B3, 32'h14, 32'h80000000, 32'hFFFFFF23);
    check("sra_rs1_addr", 32'(rs1_addr), 32'd1);
    check("sra_rs2_addr", 32'(rs2_addr), 32'd2);
    step();
    check("sra_op", 32'(op), 32'd15);
    check("sra_opa", opa, 32'h80000000);
    check("sra_opb", opb, 32'h00000003);
    step();
    check("sra_rd_we", 32'(rd_we), 32'd1);
    check("sra_rd_addr", 32'(rd_addr), 32'd3);
    step();

    // lui x7,0x12345
    issue(32'h123453B7, 32'h18, 32'h0000DEAD, 32'h0);
    step();
    check("lui_op", 32'(op), 32'd0);
    check("lui_opa", opa, 32'h0);
    check("lui_opb", opb, 32'h12345000);
    step();
    check("lui_rd_addr", 32'(rd_addr), 32'd7);
    step();

    // auipc x8,1 at pc 0x40
    issue(32'h00001417, 32'h40, 32'h0, 32'h0);
    step();
    check("auipc_opa", opa, 32'h40);
    check("auipc_opb", opb, 32'h1000);
    step();
    check("auipc_rd_we", 32'(rd_we), 32'd1);
    step();

    // jal x1,0 at pc 0x80
    issue(32'h000000EF, 32'h80, 32'h0, 32'h0);
    step();
    check("jal_opa", opa, 32'h80);
    check("jal_opb", opb, 32'h4);
    check("jal_is_jump", 32'(is_jump), 32'd1);
    check("jal_is_branch", 32'(is_branch), 32'd0);
    step();
    check("jal_phase", 32'(phase), 32'd4);
    check("jal_rd_we", 32'(rd_we), 32'd1);
    step();

    // lw x5,8(x1), ack on the third memory cycle
    issue(32'h0080A283, 32'h84, 32'h00000100, 32'h0);
    step();
    check("lw_phase", 32'(phase), 32'd2);
    check("lw_op", 32'(op), 32'd0);
    check("lw_opa", opa, 32'h100);
    check("lw_opb", opb, 32'h8);
    check("lw_mem_we", 32'(mem_we), 32'd0);
    check("lw_funct3", 32'(mem_funct3), 32'd2);
    check("lw_mem_req_exec", 32'(mem_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("lw_mem_phase", 32'(phase), 32'd3);
      check("lw_mem_req", 32'(mem_req), 32'd1);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("lw_wb_phase", 32'(phase), 32'd4);
    check("lw_mem_req_off", 32'(mem_req), 32'd0);
    check("lw_rd_we", 32'(rd_we), 32'd1);
    check("lw_rd_addr", 32'(rd_addr), 32'd5);
    step();
    check("lw_fetch", 32'(phase), 32'd0);

    // Idle: no instruction offered
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_phase", 32'(phase), 32'd0);
      check("idle_ready", 32'(instr_ready), 32'd1);
    end

    // sw x2,4(x1), reset in the middle of phase 3
    issue(32'h0020A223, 32'h88, 32'h00000200, 32'h00000055);
    step();
    check("sw_opa", opa, 32'h200);
    check("sw_opb", opb, 32'h4);
    check("sw_mem_we", 32'(mem_we), 32'd1);
    check("sw_funct3", 32'(mem_funct3), 32'd2);
    step();
    check("sw_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("sw_rst_phase", 32'(phase), 32'd0);
    check("sw_rst_mem_req", 32'(mem_req), 32'd0);
    check("sw_rst_opa", opa, 32'h0);
    check("sw_rst_mem_we", 32'(mem_we), 32'd0);

    // srai x3,x1,4
    issue(32'h4040D193, 32'h8C, 32'hF0000000, 32'h0);
    step();
    check("srai_op", 32'(op), 32'd8);
    check("srai_opb", opb, 32'h4);
    step(); step();

    // bge x1,x2
    issue(32'h0020D063, 32'h90, 32'h5, 32'h7);
    step();
    check("bge_op", 32'(op), 32'd21);
    check("bge_is_branch", 32'(is_branch), 32'd1);
    check("bge_opa", opa, 32'h5);
    check("bge_opb", opb, 32'h7);
    step();
    check("bge_phase", 32'(phase), 32'd4);
    check("bge_rd_we", 32'(rd_we), 32'd0);
    step();

    // Unknown opcode
    issue(32'hFFFFFFFF, 32'h94, 32'h12345678, 32'h9ABCDEF0);
    step();
    check("ill_flag", 32'(illegal_instr), 32'd1);
    check("ill_op", 32'(op), 32'd0);
    check("ill_opa", opa, 32'h0);
    check("ill_opb", opb, 32'h0);
    check("ill_is_branch", 32'(is_branch), 32'd0);
    step();
    check("ill_phase", 32'(phase), 32'd4);
    check("ill_rd_we", 32'(rd_we), 32'd0);
    step();
    after_illegal("ill");

    // srai with bad funct7 (0x10)
    issue(32'h2010D193, 32'h98, 32'h11111111, 32'h0);
    step();
    check("badsh_flag", 32'(illegal_instr), 32'd1);
    check("badsh_opa", opa, 32'h0);
    check("badsh_opb", opb, 32'h0);
    step();
    check("badsh_rd_we", 32'(rd_we), 32'd0);
    step();
    after_illegal("badsh");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
